// File: rtl/stack_pkg.sv
// Shared types and constants for the inter-board stack link datapath.
package stack_pkg;

  localparam int unsigned FLIT_W   = 11;
  localparam int unsigned TAIL_BIT = FLIT_W - 1;

  // All-ones flit is the link-reset code; it is forwarded like any other flit.
  localparam logic [FLIT_W-1:0] LINK_RESET_FLIT = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stack_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] sel,
  output logic             any
);

  int               pos;
  logic [PTR_W-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr is the last to win.
  always_comb begin
    sel = '0;
    any = 1'b0;
    pos = 0;
    idx = '0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = (int'(ptr) + k) % int'(N);
      idx = PTR_W'(pos);
      if (req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_link_arbiter.sv
// Wormhole round-robin arbiter sharing one stack link among NUM_REQ flit sources.
// Optional stall watchdog enabled by defining STACK_ARB_WDOG_EN.
module stack_link_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned FLIT_W      = stack_pkg::FLIT_W,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][FLIT_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             out_valid,
  output logic [FLIT_W-1:0]                out_data,
  input  logic                             out_ready,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy,
  output logic                             wdog_err
);

  import stack_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("stack_link_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;

  logic [ID_W-1:0]   pick_sel;
  logic              pick_any;
  logic [ID_W-1:0]   sel;
  logic              grant_ok;
  logic              slot_free;
  logic              accept;
  logic              tail;
  logic [FLIT_W-1:0] sel_data;
  logic              wdog_abort;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Source selection and handshake; LOCKED pins the grant to the packet owner.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel       = (state_q == LOCKED) ? lock_id_q : pick_sel;
    grant_ok  = (state_q == LOCKED) || pick_any;
    req_ready = '0;
    if (!reset && slot_free && grant_ok) begin
      req_ready[sel] = 1'b1;
    end
    sel_data = req_data[sel];
    accept   = req_ready[sel] && req_valid[sel];
    tail     = sel_data[FLIT_W-1];
  end

  // Next-state: output slot reload, packet lock/unlock, pointer advance.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      grant_d     = sel;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (tail) begin
            rr_ptr_d = sel;
          end else begin
            state_d   = LOCKED;
            lock_id_d = sel;
          end
        end
      end
      LOCKED: begin
        if ((accept && tail) || wdog_abort) begin
          state_d  = IDLE;
          rr_ptr_d = lock_id_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      lock_id_q   <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef STACK_ARB_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q;

  // Counts cycles the locked source leaves its valid low; abort on reaching the limit.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_abort = 1'b0;
    if (state_q != LOCKED || accept) begin
      wdog_cnt_d = '0;
    end else if (!req_valid[lock_id_q]) begin
      if (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
        wdog_abort = 1'b1;
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_abort;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  if (WDOG_CYCLES == 0) begin : g_wdog_cfg_check
    $error("stack_link_arbiter: WDOG_CYCLES must be non-zero");
  end

  assign wdog_abort = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stack_link_arbiter.sv
// Directed scoreboard bench for stack_link_arbiter; watchdog step runs when STACK_ARB_WDOG_EN is defined.
module tb_stack_link_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned FLIT_W  = 11;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DEPTH   = 64;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [FLIT_W-1:0] d;
  } flit_rec_t;

  typedef struct packed {
    flit_rec_t   f;
    logic [31:0] cyc;
  } obs_t;

  logic                           clk = 1'b0;
  logic                           reset = 1'b1;
  logic [NUM_REQ-1:0]             req_valid = '0;
  logic [NUM_REQ-1:0][FLIT_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           out_valid;
  logic [FLIT_W-1:0]              out_data;
  logic                           out_ready = 1'b1;
  logic [ID_W-1:0]                grant_id;
  logic                           busy;
  logic                           wdog_err;

  always #5 clk = ~clk;

  stack_link_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .FLIT_W      (FLIT_W),
    .WDOG_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .wdog_err  (wdog_err)
  );

  logic [FLIT_W-1:0] mem [NUM_REQ][DEPTH];
  int                src_wr [NUM_REQ] = '{default: 0};
  int                src_rd [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] drop  = '0;
  logic [NUM_REQ-1:0] acc_m = '0;

  flit_rec_t exp_q[$];
  obs_t      obs_q[$];

  int cyc = 0;
  int busy_cyc = 0;
  int wdog_cnt = 0;
  int wdog_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source model: each source streams its queued flits, honouring req_ready.
  always @(negedge clk) acc_m = req_valid & req_ready;

  always @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (drop[i]) src_rd[i] = src_wr[i];
      else if (acc_m[i]) src_rd[i] = src_rd[i] + 1;
    end
    #1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_valid[i] = (src_rd[i] < src_wr[i]);
      req_data[i]  = req_valid[i] ? mem[i][src_rd[i] % DEPTH] : '0;
    end
  end

  // Output monitor: records link transfers, busy cycles and watchdog pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) obs_q.push_back({grant_id, out_data, 32'(cyc)});
      if (busy) busy_cyc = busy_cyc + 1;
      if (wdog_err) begin
        wdog_cnt = wdog_cnt + 1;
        wdog_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input logic [FLIT_W-1:0] f);
    mem[s][src_wr[s] % DEPTH] = f;
    src_wr[s] = src_wr[s] + 1;
  endtask

  task automatic expect_f(input int s, input logic [FLIT_W-1:0] f);
    exp_q.push_back({ID_W'(s), f});
  endtask

  // Pops every expected flit against the observed stream; fc/lc are first/last transfer cycles.
  task automatic drain(input string tag, output int fc, output int lc);
    flit_rec_t e;
    obs_t      o;
    fc = -1;
    lc = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 40 && obs_q.size() == 0; c++) tick();
      n_cmp++;
      assert (obs_q.size() != 0)
      else begin
        n_err++;
        $error("FAIL %s: observed no flit expected %0h", tag, e);
        exp_q.delete();
        break;
      end
      o = obs_q.pop_front();
      chk(tag, 32'(o.f), 32'(e));
      if (fc < 0) fc = int'(o.cyc);
      lc = int'(o.cyc);
    end
  endtask

  task automatic chk_empty(input string tag);
    repeat (3) tick();
    chk(tag, 32'(obs_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) tick();
  endtask

  initial begin
    int fc;
    int lc;
    int b0;
    int w0;

    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdog_err", 32'(wdog_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Three-flit packet from source 0.
    b0 = busy_cyc;
    send(0, 11'h001); send(0, 11'h002); send(0, 11'h403);
    expect_f(0, 11'h001); expect_f(0, 11'h002); expect_f(0, 11'h403);
    drain("t1_stream", fc, lc);
    chk("t1_span", 32'(lc - fc), 32'd2);
    tick();
    chk("t1_busy_cycles", 32'(busy_cyc - b0), 32'd2);
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    chk_empty("t1_extra");

    // Lone single-flit from source 2 moves the pointer to 2.
    send(2, 11'h4C0);
    expect_f(2, 11'h4C0);
    drain("t2_pre", fc, lc);

    // Competing 4-flit packets from sources 0 and 1; tail of 1 is the link-reset code.
    send(0, 11'h100); send(0, 11'h101); send(0, 11'h102); send(0, 11'h503);
    send(1, 11'h210); send(1, 11'h211); send(1, 11'h212); send(1, 11'h7FF);
    expect_f(0, 11'h100); expect_f(0, 11'h101); expect_f(0, 11'h102); expect_f(0, 11'h503);
    expect_f(1, 11'h210); expect_f(1, 11'h211); expect_f(1, 11'h212); expect_f(1, 11'h7FF);
    drain("t2_wormhole", fc, lc);
    chk("t2_span", 32'(lc - fc), 32'd7);
    chk_empty("t2_extra");

    // With pointer at 1 the next contention between 0 and 2 goes to 2.
    send(0, 11'h4D0); send(2, 11'h4D2);
    expect_f(2, 11'h4D2); expect_f(0, 11'h4D0);
    drain("t2_next_rr", fc, lc);
    send(2, 11'h4C1);
    expect_f(2, 11'h4C1);
    drain("t3_pre", fc, lc);

    // Continuous single-flit tails from all sources rotate 0,1,2.
    for (int r = 0; r < 2; r++) begin
      send(0, 11'h4AA); send(1, 11'h4BB); send(2, 11'h4CC);
      expect_f(0, 11'h4AA); expect_f(1, 11'h4BB); expect_f(2, 11'h4CC);
    end
    drain("t3_rotate", fc, lc);
    chk("t3_span", 32'(lc - fc), 32'd5);
    chk_empty("t3_extra");

    // Back-pressure for 5 cycles after the head has been taken.
    out_ready = 1'b0;
    send(0, 11'h010); send(0, 11'h011); send(0, 11'h012); send(0, 11'h413);
    expect_f(0, 11'h010); expect_f(0, 11'h011); expect_f(0, 11'h012); expect_f(0, 11'h413);
    wait_out_valid();
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_data", 32'(out_data), 32'h010);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_ready_low", 32'(req_ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    drain("t4_resume", fc, lc);
    chk_empty("t4_extra");

    // Reset right after source 0's head; source 1 then wins ahead of source 2.
    send(0, 11'h020); send(0, 11'h021); send(0, 11'h422);
    wait_out_valid();
    chk("t5_head", 32'(out_data), 32'h020);
    reset = 1'b1;
    drop  = 3'b001;
    tick();
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant_id", 32'(grant_id), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();
    drop = '0;
    send(1, 11'h130); send(1, 11'h431); send(2, 11'h4C2);
    expect_f(1, 11'h130); expect_f(1, 11'h431); expect_f(2, 11'h4C2);
    drain("t5_after_reset", fc, lc);
    chk_empty("t5_extra");

`ifdef STACK_ARB_WDOG_EN
    // Source 0 stalls after its head; watchdog releases the link to source 1.
    w0 = wdog_cnt;
    send(0, 11'h060); send(1, 11'h161); send(1, 11'h462);
    expect_f(0, 11'h060); expect_f(1, 11'h161); expect_f(1, 11'h462);
    drain("t6_wdog_stream", fc, lc);
    tick();
    chk("t6_wdog_pulses", 32'(wdog_cnt - w0), 32'd1);
    chk("t6_wdog_delay", 32'(wdog_cyc - fc), 32'd8);
    chk_empty("t6_extra");
`else
    w0 = 0;
    chk("wdog_tied_low", 32'(wdog_cnt - w0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
